// File: rtl/gat_pkg.sv
// gat_pkg: constants and types shared by the new-feature write path.
//   Dataset constants (DATA_WIDTH, NUM_FEATURE_OUT, NUM_SUBGRAPHS), the derived
//   new-feature BRAM depth / address width, and the writer FSM state type.
package gat_pkg;

    localparam int DATA_WIDTH         = 8;
    localparam int NUM_FEATURE_OUT    = 16;
    localparam int NUM_SUBGRAPHS      = 2708;
    localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
    localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/new_feat_writer_if.sv
// new_feat_writer_if: aggregator -> writer feature stream (valid/ready).
//   valid : element valid        (master -> slave)
//   ready : element accepted     (slave -> master)
//   data  : signed feature value (master -> slave)
//   last  : last element of a subgraph (master -> slave)
interface new_feat_writer_if #(
    parameter int DATA_WIDTH = gat_pkg::DATA_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/new_feat_writer.sv
// new_feat_writer: writes the aggregator's feature stream into port A of the
// new-feature BRAM, one word per accepted beat, and flags layer completion.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, (re)start a layer write-back
//   feat            : feature stream, slave side (valid/ready/data/last)
//   bram_ena/wea    : port-A enable / write enable (always equal)
//   bram_addra/din  : port-A word address / write data
//   done            : level, layer fully written
//   subgraph_cnt    : subgraphs completed in the current layer
//   err             : sticky, feat_last misaligned with the feature count
//
// Build option: define FEAT_RELU_EN to clamp negative elements to zero
// before they are written (same latency).
module new_feat_writer
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH         = gat_pkg::DATA_WIDTH,
    parameter int NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
    parameter int NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int FEAT_CNT_W         = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1,
    parameter int SUBGRAPH_CNT_W     = $clog2(NUM_SUBGRAPHS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    new_feat_writer_if.slave              feat,
    output logic                          bram_ena,
    output logic                          bram_wea,
    output logic [NEW_FEATURE_ADDR_W-1:0] bram_addra,
    output logic [DATA_WIDTH-1:0]         bram_din,
    output logic                          done,
    output logic [SUBGRAPH_CNT_W-1:0]     subgraph_cnt,
    output logic                          err
);

    localparam logic [NEW_FEATURE_ADDR_W-1:0] ADDR_LAST = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [FEAT_CNT_W-1:0]         FEAT_MAX  = FEAT_CNT_W'(NUM_FEATURE_OUT - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic [NEW_FEATURE_ADDR_W-1:0] addr;
    logic [FEAT_CNT_W-1:0]         feat_cnt;
    logic [DATA_WIDTH-1:0]         din_next;
    logic                          accept;

    // start always wins over a beat presented in the same cycle
    assign accept = feat.valid && feat.ready && !start;

`ifdef FEAT_RELU_EN
    assign din_next = feat.data[DATA_WIDTH-1] ? '0 : feat.data;
`else
    assign din_next = feat.data;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE: begin
                if (start)                             state_d = WRITE;
                else if (accept && addr == ADDR_LAST)  state_d = DONE;
            end
            DONE:    if (start) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    // output logic: ready is the only combinational output
    always_comb begin
        feat.ready = (state_q == WRITE);
    end

    // done registered from next state so it rises with the final write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= (state_d == DONE);
    end

    // counters and the port-A write register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr         <= '0;
            feat_cnt     <= '0;
            subgraph_cnt <= '0;
            err          <= 1'b0;
            bram_ena     <= 1'b0;
            bram_wea     <= 1'b0;
            bram_addra   <= '0;
            bram_din     <= '0;
        end else if (start) begin
            addr         <= '0;
            feat_cnt     <= '0;
            subgraph_cnt <= '0;
            err          <= 1'b0;
            bram_ena     <= 1'b0;
            bram_wea     <= 1'b0;
        end else if (accept) begin
            bram_ena   <= 1'b1;
            bram_wea   <= 1'b1;
            bram_addra <= addr;
            bram_din   <= din_next;
            // hold at the last word rather than wrapping; the FSM leaves WRITE here
            if (addr != ADDR_LAST) addr <= addr + NEW_FEATURE_ADDR_W'(1);
            if (feat.last || feat_cnt == FEAT_MAX) begin
                // an early last realigns the count; a missing last wraps anyway
                feat_cnt     <= '0;
                subgraph_cnt <= subgraph_cnt + SUBGRAPH_CNT_W'(1);
                if (feat.last != (feat_cnt == FEAT_MAX)) err <= 1'b1;
            end else begin
                feat_cnt <= feat_cnt + FEAT_CNT_W'(1);
            end
        end else begin
            bram_ena <= 1'b0;
            bram_wea <= 1'b0;
        end
    end

endmodule

// File: tb/tb_new_feat_writer.sv
module tb_new_feat_writer;

    localparam int DW   = 8;
    localparam int NFO  = 4;
    localparam int NSG  = 2;
    localparam int AW   = 3;
    localparam int SGW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bram_ena, bram_wea, done, err;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_din;
    logic [SGW-1:0] subgraph_cnt;

    int vectors    = 0;
    int miscompares = 0;

    new_feat_writer_if #(.DATA_WIDTH(DW)) fif ();

    new_feat_writer #(
        .DATA_WIDTH(DW), .NUM_FEATURE_OUT(NFO), .NUM_SUBGRAPHS(NSG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .feat(fif),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_din(bram_din), .done(done), .subgraph_cnt(subgraph_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_din(input logic [DW-1:0] d);
`ifdef FEAT_RELU_EN
        return d[DW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present one beat, clock it, check the write strobe one cycle later
    task automatic beat(input logic [DW-1:0] d, input logic lst, input logic [AW-1:0] a);
        fif.valid = 1'b1; fif.data = d; fif.last = lst;
        chk("ready_before_beat", fif.ready, 1);
        @(posedge clk); #1;
        fif.valid = 1'b0; fif.last = 1'b0;
        chk("wr_ena", bram_ena, 1);
        chk("wr_wea", bram_wea, 1);
        chk("wr_addr", bram_addra, a);
        chk("wr_din", bram_din, exp_din(d));
    endtask

    task automatic idle_cycle();
        fif.valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_strobe", bram_ena, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        fif.valid = 1'b0; fif.data = '0; fif.last = 1'b0;
        #12;
        chk("rst_ready", fif.ready, 0);
        chk("rst_ena", bram_ena, 0);
        chk("rst_wea", bram_wea, 0);
        chk("rst_addr", bram_addra, 0);
        chk("rst_din", bram_din, 0);
        chk("rst_done", done, 0);
        chk("rst_sgcnt", subgraph_cnt, 0);
        chk("rst_err", err, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", fif.ready, 0);

        // full layer, back to back
        pulse_start();
        chk("write_ready", fif.ready, 1);
        for (int i = 0; i < 8; i++) begin
            beat(DW'(i + 1), (i == 3) || (i == 7), AW'(i));
            if (i == 3) chk("sg_after_4", subgraph_cnt, 1);
            if (i == 6) chk("done_before_last", done, 0);
        end
        chk("done_with_last_write", done, 1);
        chk("sg_final", subgraph_cnt, 2);
        chk("err_clean", err, 0);
        chk("ready_in_done", fif.ready, 0);

        // beats held valid in DONE are ignored
        fif.valid = 1'b1; fif.data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("done_no_write", bram_ena, 0);
            chk("done_ready", fif.ready, 0);
            chk("done_held", done, 1);
        end
        fif.valid = 1'b0;

        // gaps between beats, plus ReLU corner values
        pulse_start();
        chk("restart_done_clr", done, 0);
        beat(8'h10, 1'b0, 3'd0);
        idle_cycle();
        beat(8'hF0, 1'b0, 3'd1);
        idle_cycle();
        idle_cycle();
        beat(8'h7F, 1'b0, 3'd2);
        beat(8'h80, 1'b1, 3'd3);
        idle_cycle();
        beat(8'h14, 1'b0, 3'd4);
        beat(8'h15, 1'b0, 3'd5);
        idle_cycle();
        beat(8'h16, 1'b0, 3'd6);
        beat(8'h17, 1'b1, 3'd7);
        chk("gap_done", done, 1);
        chk("gap_err", err, 0);
        chk("gap_sg", subgraph_cnt, 2);

        // early feat_last on beat 3
        pulse_start();
        beat(8'h21, 1'b0, 3'd0);
        beat(8'h22, 1'b0, 3'd1);
        chk("err_before_early", err, 0);
        beat(8'h23, 1'b1, 3'd2);
        chk("early_err", err, 1);
        chk("early_sg", subgraph_cnt, 1);
        beat(8'h24, 1'b0, 3'd3);
        beat(8'h25, 1'b0, 3'd4);
        beat(8'h26, 1'b0, 3'd5);
        chk("realign_sg_hold", subgraph_cnt, 1);
        beat(8'h27, 1'b1, 3'd6);
        chk("realign_sg", subgraph_cnt, 2);
        chk("err_sticky", err, 1);
        // start together with the final beat: start wins
        fif.valid = 1'b1; fif.data = 8'h28; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fif.valid = 1'b0;
        chk("start_win_no_write", bram_ena, 0);
        chk("start_win_done", done, 0);
        chk("start_win_ready", fif.ready, 1);
        chk("start_win_sg", subgraph_cnt, 0);
        chk("start_win_err", err, 0);

        // missing feat_last at max count, then mid-layer restart
        for (int i = 0; i < 5; i++) beat(DW'(8'h30 + i), 1'b0, AW'(i));
        chk("miss_last_err", err, 1);
        chk("miss_last_sg", subgraph_cnt, 1);
        fif.valid = 1'b1; fif.data = 8'h3F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fif.valid = 1'b0;
        chk("abort_no_write", bram_ena, 0);
        chk("abort_err", err, 0);
        chk("abort_sg", subgraph_cnt, 0);
        beat(8'h41, 1'b0, 3'd0);
        beat(8'h42, 1'b0, 3'd1);

        // asynchronous reset while the strobe is high
        #3 rst = 1'b1;
        #1;
        chk("arst_ena", bram_ena, 0);
        chk("arst_wea", bram_wea, 0);
        chk("arst_addr", bram_addra, 0);
        chk("arst_din", bram_din, 0);
        chk("arst_ready", fif.ready, 0);
        chk("arst_sg", subgraph_cnt, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        @(negedge clk); rst = 1'b0;
        fif.valid = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle_ready", fif.ready, 0);
        chk("post_rst_no_write", bram_ena, 0);
        fif.valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
